// File: rtl/alu_issue_pkg.sv
// Shared types and constants for the ALU issue stage: operand width,
// ALU opCode values, RV32I major opcodes, the decoded-entry record and
// the buffer state encoding.
package alu_issue_pkg;

    localparam int DATA_W = 32;

    // ALU operation codes as seen on opCode
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b1000;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_AND = 4'b0111;
    localparam logic [3:0] ALU_OR  = 4'b0110;

    // RV32I major opcodes handled by this stage
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // One decoded instruction as it travels through the buffer
    typedef struct packed {
        logic [DATA_W-1:0] op_a;
        logic [DATA_W-1:0] op_b;
        logic [3:0]        op_code;
        logic [4:0]        rd;
        logic              illegal;
    } entry_t;

    // Buffer occupancy: output register only (HALF) or both registers (FULL)
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HALF  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_issue_if.sv
// Handshake bundle between decode, the issue stage and the ALU.
// master = upstream/downstream environment, slave = the issue stage.
interface alu_issue_if;
    import alu_issue_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [31:0]       instr;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] opA;
    logic [DATA_W-1:0] opB;
    logic [3:0]        opCode;
    logic [4:0]        rd;
    logic              illegal;

    modport master (
        output in_valid, instr, pc, rs1_data, rs2_data, flush, out_ready,
        input  in_ready, out_valid, opA, opB, opCode, rd, illegal
    );

    modport slave (
        input  in_valid, instr, pc, rs1_data, rs2_data, flush, out_ready,
        output in_ready, out_valid, opA, opB, opCode, rd, illegal
    );
endinterface

// File: rtl/alu_issue_decode.sv
// Combinational RV32I integer-ALU decode: turns an instruction plus its
// pc and register reads into an ALU entry. Unsupported encodings yield an
// entry flagged illegal with zero operands and ADD.
module alu_issue_decode
    import alu_issue_pkg::*;
(
    input  logic [31:0]       instr,
    input  logic [DATA_W-1:0] pc,
    input  logic [DATA_W-1:0] rs1_data,
    input  logic [DATA_W-1:0] rs2_data,
    output entry_t            entry
);

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [DATA_W-1:0] imm_i;
    logic [DATA_W-1:0] imm_u;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign imm_i  = {{(DATA_W-12){instr[31]}}, instr[31:20]};
    assign imm_u  = {instr[31:12], 12'b0};

    logic              legal;
    logic [3:0]        code;
    logic [DATA_W-1:0] a_sel;
    logic [DATA_W-1:0] b_sel;

    // Operand/opcode selection by instruction format
    always_comb begin
        legal = 1'b0;
        code  = ALU_ADD;
        a_sel = '0;
        b_sel = '0;
        unique case (opcode)
            OPC_OP: begin
                a_sel = rs1_data;
                b_sel = rs2_data;
                case (funct3)
                    3'b000: begin
                        if (funct7 == 7'b0000000) begin
                            legal = 1'b1;
                            code  = ALU_ADD;
                        end else if (funct7 == 7'b0100000) begin
                            legal = 1'b1;
                            code  = ALU_SUB;
                        end
                    end
                    3'b100: begin
                        legal = (funct7 == 7'b0000000);
                        code  = ALU_XOR;
                    end
                    3'b110: begin
                        legal = (funct7 == 7'b0000000);
                        code  = ALU_OR;
                    end
                    3'b111: begin
                        legal = (funct7 == 7'b0000000);
                        code  = ALU_AND;
                    end
                    default: legal = 1'b0;
                endcase
            end
            OPC_OP_IMM: begin
                a_sel = rs1_data;
                b_sel = imm_i;
                case (funct3)
                    3'b000: begin legal = 1'b1; code = ALU_ADD; end
                    3'b100: begin legal = 1'b1; code = ALU_XOR; end
                    3'b110: begin legal = 1'b1; code = ALU_OR;  end
                    3'b111: begin legal = 1'b1; code = ALU_AND; end
                    default: legal = 1'b0;
                endcase
            end
            OPC_LUI: begin
                legal = 1'b1;
                a_sel = '0;
                b_sel = imm_u;
            end
            OPC_AUIPC: begin
                legal = 1'b1;
                a_sel = pc;
                b_sel = imm_u;
            end
            default: legal = 1'b0;
        endcase
    end

    // Illegal entries still carry rd but have their payload neutralised
    always_comb begin
        entry         = '0;
        entry.rd      = instr[11:7];
        entry.illegal = !legal;
        if (legal) begin
            entry.op_a    = a_sel;
            entry.op_b    = b_sel;
            entry.op_code = code;
        end
    end

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: decodes an instruction and holds the ALU operands in
// registers behind a valid/ready handshake.
// ALU_ISSUE_SKID_EN defined   : two-entry skid buffer, registered in_ready.
// ALU_ISSUE_SKID_EN undefined : single output register, in_ready is
//                               combinational (!out_valid || out_ready).
module alu_issue
    import alu_issue_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    alu_issue_if.slave  bus
);

    entry_t dec_entry;

    alu_issue_decode u_decode (
        .instr    (bus.instr),
        .pc       (bus.pc),
        .rs1_data (bus.rs1_data),
        .rs2_data (bus.rs2_data),
        .entry    (dec_entry)
    );

    state_t state_reg;
    state_t state_next;
    entry_t out_reg;
    logic   out_valid_int;
    logic   in_ready_int;
    logic   in_xfer;
    logic   out_xfer;
    logic   load_out_dec;

    assign out_valid_int = (state_reg != ST_EMPTY);
    assign out_xfer      = out_valid_int && bus.out_ready;
    assign in_xfer       = bus.in_valid && in_ready_int;

`ifdef ALU_ISSUE_SKID_EN
    entry_t skid_reg;
    logic   in_ready_reg;
    logic   load_out_skid;
    logic   load_skid;

    assign in_ready_int = in_ready_reg;

    // Next occupancy and register load enables; flush overrides all transfers
    always_comb begin
        state_next    = state_reg;
        load_out_dec  = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        if (bus.flush) begin
            state_next = ST_EMPTY;
        end else begin
            case (state_reg)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        state_next   = ST_HALF;
                        load_out_dec = 1'b1;
                    end
                end
                ST_HALF: begin
                    if (in_xfer && out_xfer) begin
                        load_out_dec = 1'b1;
                    end else if (in_xfer) begin
                        state_next = ST_FULL;
                        load_skid  = 1'b1;
                    end else if (out_xfer) begin
                        state_next = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_xfer) begin
                        state_next    = ST_HALF;
                        load_out_skid = 1'b1;
                    end
                end
                default: state_next = ST_EMPTY;
            endcase
        end
    end

    // in_ready is a function of the next occupancy only, so it is registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready_reg <= 1'b1;
        end else begin
            in_ready_reg <= (state_next != ST_FULL);
        end
    end

    // Skid register captures an entry arriving while the output is stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_reg <= '0;
        end else if (load_skid) begin
            skid_reg <= dec_entry;
        end
    end

    // Output register refills from decode directly or from the skid register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_reg <= '0;
        end else if (load_out_dec) begin
            out_reg <= dec_entry;
        end else if (load_out_skid) begin
            out_reg <= skid_reg;
        end
    end
`else
    assign in_ready_int = !out_valid_int || bus.out_ready;

    // Next occupancy for the single-register buffer; flush overrides transfers
    always_comb begin
        state_next   = state_reg;
        load_out_dec = 1'b0;
        if (bus.flush) begin
            state_next = ST_EMPTY;
        end else if (in_xfer) begin
            // When HALF, in_xfer implies the current entry leaves this cycle
            state_next   = ST_HALF;
            load_out_dec = 1'b1;
        end else if (out_xfer) begin
            state_next = ST_EMPTY;
        end
    end

    // Output register loads every accepted instruction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_reg <= '0;
        end else if (load_out_dec) begin
            out_reg <= dec_entry;
        end
    end
`endif

    // Buffer occupancy register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = out_valid_int;
    assign bus.opA       = out_reg.op_a;
    assign bus.opB       = out_reg.op_b;
    assign bus.opCode    = out_reg.op_code;
    assign bus.rd        = out_reg.rd;
    assign bus.illegal   = out_reg.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed vector table, hand-written
// backpressure/flush/async-reset sequences, then random traffic against a
// queue-based reference model. Works with or without ALU_ISSUE_SKID_EN.
module tb_alu_issue;

    logic clk;
    logic rst;

    alu_issue_if bus ();

    alu_issue dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

`ifdef ALU_ISSUE_SKID_EN
    localparam int CAPACITY = 2;
`else
    localparam int CAPACITY = 1;
`endif

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  code;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        logic [3:0]  exp_code;
        logic [4:0]  exp_rd;
        logic        exp_ill;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    // Reference decode: what the ALU should be asked to do, per instruction class
    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pcv,
                                        input logic [31:0] r1, input logic [31:0] r2);
        exp_t        e;
        int          imm;
        logic [31:0] upper;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [3:0]  logic_code;
        bit          is_logic;
        f3    = ins[14:12];
        f7    = ins[31:25];
        imm   = int'($signed(ins[31:20]));
        upper = (ins >> 12) << 12;
        is_logic   = (f3 == 3'd4) || (f3 == 3'd6) || (f3 == 3'd7);
        logic_code = (f3 == 3'd4) ? 4'b0100 : (f3 == 3'd6) ? 4'b0110 : 4'b0111;
        e.a = 0; e.b = 0; e.code = 4'b0000; e.rd = ins[11:7]; e.ill = 1'b1;
        if (ins[6:0] == 7'h33) begin
            if (f3 == 3'd0 && f7 == 7'h00) begin e.a = r1; e.b = r2; e.code = 4'b0000; e.ill = 0; end
            else if (f3 == 3'd0 && f7 == 7'h20) begin e.a = r1; e.b = r2; e.code = 4'b1000; e.ill = 0; end
            else if (is_logic && f7 == 7'h00) begin e.a = r1; e.b = r2; e.code = logic_code; e.ill = 0; end
        end else if (ins[6:0] == 7'h13) begin
            if (f3 == 3'd0) begin e.a = r1; e.b = 32'(imm); e.code = 4'b0000; e.ill = 0; end
            else if (is_logic) begin e.a = r1; e.b = 32'(imm); e.code = logic_code; e.ill = 0; end
        end else if (ins[6:0] == 7'h37) begin
            e.a = 0; e.b = upper; e.ill = 0;
        end else if (ins[6:0] == 7'h17) begin
            e.a = pcv; e.b = upper; e.ill = 0;
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [6:0]  op;
        w = $urandom;
        case ($urandom_range(0, 5))
            0, 1: op = 7'h33;
            2, 3: op = 7'h13;
            4:    op = ($urandom_range(0, 1) == 0) ? 7'h37 : 7'h17;
            default: op = 7'($urandom);
        endcase
        case ($urandom_range(0, 3))
            0, 1: w[31:25] = 7'h00;
            2:    w[31:25] = 7'h20;
            default: ;
        endcase
        w[6:0] = op;
        return w;
    endfunction

    task automatic idle_inputs();
        bus.in_valid  = 1'b0;
        bus.instr     = 32'h0;
        bus.pc        = 32'h0;
        bus.rs1_data  = 32'h0;
        bus.rs2_data  = 32'h0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    task automatic check_outputs(input string tag, input exp_t e);
        check({tag, "_opA"},    bus.opA, e.a);
        check({tag, "_opB"},    bus.opB, e.b);
        check({tag, "_opCode"}, 32'(bus.opCode), 32'(e.code));
        check({tag, "_rd"},     32'(bus.rd), 32'(e.rd));
        check({tag, "_illegal"}, 32'(bus.illegal), 32'(e.ill));
    endtask

    vec_t vecs[8];
    exp_t q[$];
    exp_t e;
    logic [4:0] got_rd[$];

    initial begin
        vecs[0] = '{"sub",      32'h40208033, 32'h0,   32'd10, 32'd3, 32'd10,  32'd3,        4'b1000, 5'd0, 1'b0};
        vecs[1] = '{"addi_neg", 32'hFFF08093, 32'h0,   32'd5,  32'd9, 32'd5,   32'hFFFFFFFF, 4'b0000, 5'd1, 1'b0};
        vecs[2] = '{"lui",      32'h123451B7, 32'h44,  32'd7,  32'd8, 32'h0,   32'h12345000, 4'b0000, 5'd3, 1'b0};
        vecs[3] = '{"auipc",    32'h00001217, 32'h100, 32'd7,  32'd8, 32'h100, 32'h00001000, 4'b0000, 5'd4, 1'b0};
        vecs[4] = '{"sll",      32'h00209033, 32'h0,   32'd7,  32'd9, 32'h0,   32'h0,        4'b0000, 5'd0, 1'b1};
        vecs[5] = '{"xor",      32'h007342B3, 32'h0,   32'hF0, 32'hAA, 32'hF0, 32'hAA,       4'b0100, 5'd5, 1'b0};
        vecs[6] = '{"andi",     32'h7FF0F113, 32'h0,   32'h1234, 32'h0, 32'h1234, 32'h7FF,   4'b0111, 5'd2, 1'b0};
        vecs[7] = '{"or_badf7", 32'h4020E033, 32'h0,   32'd1,  32'd2, 32'h0,   32'h0,        4'b0000, 5'd0, 1'b1};

        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready",  32'(bus.in_ready), 32'd1);
        check("rst_opA", bus.opA, 32'h0);
        check("rst_opCode", 32'(bus.opCode), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Vector table, issued back to back with the ALU always ready
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.instr    = vecs[i].instr;
            bus.pc       = vecs[i].pc;
            bus.rs1_data = vecs[i].rs1;
            bus.rs2_data = vecs[i].rs2;
            #1;
            check({vecs[i].name, "_in_ready"}, 32'(bus.in_ready), 32'd1);
            @(posedge clk);
            #1;
            check({vecs[i].name, "_out_valid"}, 32'(bus.out_valid), 32'd1);
            e = '{vecs[i].exp_a, vecs[i].exp_b, vecs[i].exp_code, vecs[i].exp_rd, vecs[i].exp_ill};
            check_outputs(vecs[i].name, e);
            $display("vec %0d %s: instr=0x%08h opA=0x%08h opB=0x%08h opCode=%b rd=%0d illegal=%b",
                     i, vecs[i].name, vecs[i].instr, bus.opA, bus.opB, bus.opCode, bus.rd, bus.illegal);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("drain_out_valid", 32'(bus.out_valid), 32'd0);

        // Backpressure: three ADDIs with distinct rd while the ALU stalls
        bus.out_ready = 1'b0;
        bus.rs1_data  = 32'd100;
        bus.in_valid  = 1'b1;
        bus.instr     = 32'h00100593;            // addi x11,x0,1
        #1;
        check("bp_ready0", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.instr = 32'h00200613;                // addi x12,x0,2
        #1;
        check("bp_ready1", 32'(bus.in_ready), (CAPACITY == 2) ? 32'd1 : 32'd0);
        if (CAPACITY == 2) begin
            @(negedge clk);
            #1;
            bus.instr = 32'h00300693;            // addi x13,x0,3
            check("bp_ready2", 32'(bus.in_ready), 32'd0);
            check("bp_hold_rd", 32'(bus.rd), 32'd11);
        end
        // Release the ALU and let everything drain, bounded
        got_rd.delete();
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
            #1;
            if (bus.out_valid) got_rd.push_back(bus.rd);
            if (bus.in_valid && bus.in_ready) begin
                @(posedge clk);
                #1;
                if (bus.instr == 32'h00100593) bus.instr = 32'h00200613;
                else if (bus.instr == 32'h00200613) bus.instr = 32'h00300693;
                else bus.in_valid = 1'b0;
            end
            if (!bus.in_valid && !bus.out_valid) break;
        end
        bus.in_valid = 1'b0;
        check("bp_count", 32'(got_rd.size()), 32'd3);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("bp_order%0d", k), (k < got_rd.size()) ? 32'(got_rd[k]) : 32'hDEAD, 32'(11 + k));
        end
        $display("backpressure: delivered %0d entries", got_rd.size());

        // Flush with the buffer full and an input presented
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.instr     = 32'h00100593;
        repeat (CAPACITY) @(negedge clk);
        #1;
        check("fl_full_in_ready", 32'(bus.in_ready), (CAPACITY == 2) ? 32'd0 : 32'd0);
        bus.flush = 1'b1;
        bus.instr = 32'h00700793;                // addi x15,x0,7 (must be lost)
        @(posedge clk);
        #1;
        check("fl_out_valid", 32'(bus.out_valid), 32'd0);
        check("fl_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("fl_lost", 32'(bus.out_valid), 32'd0);
        $display("flush: out_valid=%b in_ready=%b", bus.out_valid, bus.in_ready);

        // Asynchronous reset between clock edges
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.instr     = 32'h00108093;            // addi x1,x1,1
        bus.rs1_data  = 32'h55;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("ar_pre_valid", 32'(bus.out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("ar_out_valid", 32'(bus.out_valid), 32'd0);
        check("ar_opA", bus.opA, 32'h0);
        check("ar_opB", bus.opB, 32'h0);
        check("ar_rd", 32'(bus.rd), 32'd0);
        check("ar_in_ready", 32'(bus.in_ready), 32'd1);
        $display("async reset: out_valid=%b opA=0x%08h", bus.out_valid, bus.opA);
        @(negedge clk);
        rst = 1'b0;

        // Random traffic against the queue model
        q.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic exp_ready;
            logic exp_valid;
            @(negedge clk);
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.instr     = rand_instr();
            bus.pc        = $urandom;
            bus.rs1_data  = $urandom;
            bus.rs2_data  = $urandom;
            bus.out_ready = ($urandom_range(0, 2) != 0);
            bus.flush     = ($urandom_range(0, 49) == 0);
            #1;
            exp_valid = (q.size() != 0);
`ifdef ALU_ISSUE_SKID_EN
            exp_ready = (q.size() < CAPACITY);
`else
            exp_ready = (q.size() == 0) || bus.out_ready;
`endif
            check("rnd_out_valid", 32'(bus.out_valid), 32'(exp_valid));
            check("rnd_in_ready", 32'(bus.in_ready), 32'(exp_ready));
            if (exp_valid) check_outputs("rnd", q[0]);
            if (bus.flush) begin
                q.delete();
            end else begin
                if (exp_valid && bus.out_ready) void'(q.pop_front());
                if (bus.in_valid && exp_ready)
                    q.push_back(ref_decode(bus.instr, bus.pc, bus.rs1_data, bus.rs2_data));
            end
        end
        $display("random: %0d cycles done, %0d entries left", 3000, q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
